// File: rtl/pong_ai_paddle.sv
// pong_ai_paddle: computer opponent that drives paddle 2 by issuing
// active-low up/down requests. Every SAMPLE_PSC cycles it samples the ball.
// It chases the ball after a reaction delay when the ball is approaching.
// When the ball is receding it returns the paddle to HOME_Y.
//
// Ports
//   clk_0      pixel clock
//   rst        asynchronous active-low reset
//   enable     AI owns paddle 2 while high
//   sq_shown   ball visible
//   game_over  game-over pulse
//   sq_xpos    ball left x
//   sq_ypos    ball top y
//   pdl_ypos   controlled paddle top y
//   up_n       active-low up request (to up_p2)
//   down_n     active-low down request (to down_p2)
//   state      current FSM state
module pong_ai_paddle #(
   parameter int SQ_WIDTH    = 16,
   parameter int PDL_HEIGHT  = 96,
   parameter int V_VIDEO     = 480,
   parameter int HOME_Y      = 191,
   parameter int DEAD_ZONE   = 8,
   parameter int SAMPLE_PSC  = 251_750,
   parameter int REACT_TICKS = 3
) (
   input  logic       clk_0,
   input  logic       rst,
   input  logic       enable,
   input  logic       sq_shown,
   input  logic       game_over,
   input  logic [9:0] sq_xpos,
   input  logic [9:0] sq_ypos,
   input  logic [9:0] pdl_ypos,
   output logic       up_n,
   output logic       down_n,
   output logic [2:0] state
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] WAIT      = 3'd1;
   localparam logic [2:0] MOVE_UP   = 3'd2;
   localparam logic [2:0] MOVE_DOWN = 3'd3;
   localparam logic [2:0] RECENTER  = 3'd4;

   localparam int CW = (SAMPLE_PSC > 1) ? $clog2(SAMPLE_PSC) : 1;
   localparam int RW = (REACT_TICKS > 1) ? $clog2(REACT_TICKS) : 1;
   localparam logic [CW-1:0] CNT_LAST   = CW'(SAMPLE_PSC - 1);
   localparam logic [RW-1:0] REACT_LOAD = RW'(REACT_TICKS - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [RW-1:0] react_q, react_d;
   logic [9:0]    prev_x_q, prev_x_d;
   logic          prev_valid_q, prev_valid_d;
   logic [2:0]    state_q, state_d;
   logic          up_n_q, up_n_d;
   logic          down_n_q, down_n_d;

   logic              tick;
   logic              abort;
   logic              approaching;
   logic [11:0]       sq_c, pdl_c, home_c;
   logic signed [11:0] err, herr;
   logic [11:0]       err_mag, herr_mag;
   logic              err_big, herr_big;
   logic              at_top, at_bottom;

   assign tick  = (cnt_q == CNT_LAST);
   assign abort = !enable || !sq_shown || game_over;
   assign approaching = prev_valid_q && (sq_xpos > prev_x_q);

   // Centre-to-centre distances. Operands are zero-extended so that
   // 12-bit wraparound gives the correct signed result.
   assign sq_c   = {2'b00, sq_ypos} + 12'(SQ_WIDTH / 2);
   assign pdl_c  = {2'b00, pdl_ypos} + 12'(PDL_HEIGHT / 2);
   assign home_c = 12'(HOME_Y + PDL_HEIGHT / 2);
   assign err    = $signed(sq_c - pdl_c);
   assign herr   = $signed(home_c - pdl_c);

   assign err_mag  = err[11]  ? 12'(-err)  : 12'(err);
   assign herr_mag = herr[11] ? 12'(-herr) : 12'(herr);
   assign err_big  = err_mag  > 12'(DEAD_ZONE);
   assign herr_big = herr_mag > 12'(DEAD_ZONE);

   assign at_top    = (pdl_ypos == '0);
   assign at_bottom = ({2'b00, pdl_ypos} + 12'(PDL_HEIGHT)) >= 12'(V_VIDEO - 1);

   always_comb begin
      cnt_d        = tick ? '0 : cnt_q + 1'b1;
      prev_x_d     = tick ? sq_xpos : prev_x_q;
      prev_valid_d = abort ? 1'b0 : (tick ? 1'b1 : prev_valid_q);
      state_d      = state_q;
      react_d      = react_q;

      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               // Decisions wait for one valid x sample, so the first tick
               // after reset or abort only records the ball position.
               if (tick && prev_valid_q) begin
                  if (approaching && err_big) begin
                     state_d = WAIT;
                     react_d = REACT_LOAD;
                  end else if (!approaching && herr_big) begin
                     state_d = RECENTER;
                  end
               end
            end
            WAIT: begin
               if (tick) begin
                  if (react_q != '0)
                     react_d = react_q - 1'b1;
                  else if (!err_big || !approaching)
                     state_d = IDLE;
                  else if (err[11])
                     state_d = MOVE_UP;
                  else
                     state_d = MOVE_DOWN;
               end
            end
            MOVE_UP: begin
               if (at_top)
                  state_d = IDLE;
               else if (tick && (!err_big || !err[11] || !approaching))
                  state_d = IDLE;
            end
            MOVE_DOWN: begin
               if (at_bottom)
                  state_d = IDLE;
               else if (tick && (!err_big || err[11] || !approaching))
                  state_d = IDLE;
            end
            RECENTER: begin
               // The boundary check follows whichever request is being driven.
               if ((!up_n_q && at_top) || (!down_n_q && at_bottom)) begin
                  state_d = IDLE;
               end else if (tick) begin
                  if (approaching && err_big) begin
                     state_d = WAIT;
                     react_d = REACT_LOAD;
                  end else if (!herr_big) begin
                     state_d = IDLE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // Requests are decoded from the current state, so they lag it by one cycle.
      up_n_d   = !((state_q == MOVE_UP) || ((state_q == RECENTER) && herr[11]));
      down_n_d = !((state_q == MOVE_DOWN) ||
                   ((state_q == RECENTER) && !herr[11] && (herr != '0)));
   end

   always_ff @(posedge clk_0 or negedge rst) begin
      if (!rst) begin
         cnt_q        <= '0;
         react_q      <= '0;
         prev_x_q     <= '0;
         prev_valid_q <= 1'b0;
         state_q      <= IDLE;
         up_n_q       <= 1'b1;
         down_n_q     <= 1'b1;
      end else begin
         cnt_q        <= cnt_d;
         react_q      <= react_d;
         prev_x_q     <= prev_x_d;
         prev_valid_q <= prev_valid_d;
         state_q      <= state_d;
         up_n_q       <= up_n_d;
         down_n_q     <= down_n_d;
      end
   end

   assign up_n   = up_n_q;
   assign down_n = down_n_q;
   assign state  = state_q;

endmodule

// File: tb/tb_pong_ai_paddle.sv
// Directed bench for pong_ai_paddle with a four-cycle sample tick and a
// two-tick reaction delay. Expected values are queued when stimulus is
// applied and compared against the DUT after the clock advances.
module tb_pong_ai_paddle;

   logic       clk_0;
   logic       rst;
   logic       enable;
   logic       sq_shown;
   logic       game_over;
   logic [9:0] sq_xpos;
   logic [9:0] sq_ypos;
   logic [9:0] pdl_ypos;
   logic       up_n;
   logic       down_n;
   logic [2:0] state;

   pong_ai_paddle #(
      .SAMPLE_PSC (4),
      .REACT_TICKS(2),
      .DEAD_ZONE  (8)
   ) dut (
      .clk_0    (clk_0),
      .rst      (rst),
      .enable   (enable),
      .sq_shown (sq_shown),
      .game_over(game_over),
      .sq_xpos  (sq_xpos),
      .sq_ypos  (sq_ypos),
      .pdl_ypos (pdl_ypos),
      .up_n     (up_n),
      .down_n   (down_n),
      .state    (state)
   );

   initial clk_0 = 1'b0;
   always #5 clk_0 = ~clk_0;

   typedef struct {
      string      tag;
      logic [2:0] st;
      logic       up;
      logic       dn;
   } exp_t;

   exp_t sbq[$];
   int   errors = 0;
   int   checks = 0;
   int   tb_cnt = 0;
   logic tick_seen = 1'b0;

   task automatic push(input string tag, input logic [2:0] st, input logic up, input logic dn);
      exp_t e;
      e.tag = tag;
      e.st  = st;
      e.up  = up;
      e.dn  = dn;
      sbq.push_back(e);
   endtask

   task automatic chk();
      exp_t e;
      if (sbq.size() == 0) begin
         errors++;
         checks++;
         $error("FAIL scoreboard_empty: got 0 entries expected >=1");
      end else begin
         e = sbq.pop_front();
         checks++;
         assert (state === e.st) else begin
            errors++;
            $error("FAIL %s.state: got %0d expected %0d", e.tag, state, e.st);
         end
         checks++;
         assert (up_n === e.up) else begin
            errors++;
            $error("FAIL %s.up_n: got %b expected %b", e.tag, up_n, e.up);
         end
         checks++;
         assert (down_n === e.dn) else begin
            errors++;
            $error("FAIL %s.down_n: got %b expected %b", e.tag, down_n, e.dn);
         end
      end
   endtask

   // One clock; tick_seen reports whether that edge was a sample tick.
   task automatic step();
      tick_seen = (tb_cnt == 3);
      @(posedge clk_0);
      tb_cnt = (tb_cnt + 1) % 4;
      @(negedge clk_0);
   endtask

   task automatic next_tick();
      for (int i = 0; i < 8; i++) begin
         step();
         if (tick_seen) break;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b0;
      enable    = 1'b1;
      sq_shown  = 1'b1;
      game_over = 1'b0;
      sq_xpos   = 10'd300;
      sq_ypos   = 10'd100;
      pdl_ypos  = 10'd191;
      repeat (3) @(negedge clk_0);
      push("reset", 3'd0, 1'b1, 1'b1);
      chk();
      rst    = 1'b1;
      tb_cnt = 0;

      // Approach from above: first tick only records x=300
      push("first_tick", 3'd0, 1'b1, 1'b1);
      next_tick();
      chk();
      sq_xpos = 10'd302;
      push("approach_wait", 3'd1, 1'b1, 1'b1);
      next_tick();
      chk();
      sq_xpos = 10'd304;
      push("react_1", 3'd1, 1'b1, 1'b1);
      next_tick();
      chk();
      sq_xpos = 10'd306;
      push("move_up", 3'd2, 1'b1, 1'b1);
      next_tick();
      chk();
      push("up_active", 3'd2, 1'b0, 1'b1);
      step();
      chk();

      // Top boundary exit between ticks
      pdl_ypos = 10'd0;
      push("top_exit", 3'd0, 1'b0, 1'b1);
      step();
      chk();
      push("top_release", 3'd0, 1'b1, 1'b1);
      step();
      chk();

      // Dead zone: err = -4 while approaching
      pdl_ypos = 10'd191;
      sq_ypos  = 10'd227;
      sq_xpos  = 10'd308;
      push("dead_zone_a", 3'd0, 1'b1, 1'b1);
      next_tick();
      chk();
      sq_xpos = 10'd310;
      push("dead_zone_b", 3'd0, 1'b1, 1'b1);
      next_tick();
      chk();

      // Receding recenter
      sq_xpos = 10'd400;
      push("recede_prep", 3'd0, 1'b1, 1'b1);
      next_tick();
      chk();
      sq_xpos  = 10'd398;
      pdl_ypos = 10'd50;
      push("recenter", 3'd4, 1'b1, 1'b1);
      next_tick();
      chk();
      push("recenter_down", 3'd4, 1'b1, 1'b0);
      step();
      chk();
      pdl_ypos = 10'd188;
      push("recenter_home", 3'd0, 1'b1, 1'b0);
      next_tick();
      chk();
      push("recenter_release", 3'd0, 1'b1, 1'b1);
      step();
      chk();

      // Abort out of WAIT
      sq_xpos = 10'd402;
      sq_ypos = 10'd100;
      push("abort_wait", 3'd1, 1'b1, 1'b1);
      next_tick();
      chk();
      sq_shown = 1'b0;
      push("abort_idle", 3'd0, 1'b1, 1'b1);
      step();
      chk();
      sq_shown = 1'b1;
      sq_xpos  = 10'd404;
      push("abort_no_wait", 3'd0, 1'b1, 1'b1);
      next_tick();
      chk();

      // Move down, then asynchronous reset mid-move
      sq_ypos = 10'd300;
      sq_xpos = 10'd406;
      push("down_wait", 3'd1, 1'b1, 1'b1);
      next_tick();
      chk();
      sq_xpos = 10'd408;
      push("down_react", 3'd1, 1'b1, 1'b1);
      next_tick();
      chk();
      sq_xpos = 10'd410;
      push("move_down", 3'd3, 1'b1, 1'b1);
      next_tick();
      chk();
      push("down_active", 3'd3, 1'b1, 1'b0);
      step();
      chk();
      #2;
      rst = 1'b0;
      #1;
      push("async_reset", 3'd0, 1'b1, 1'b1);
      chk();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pong_ai_paddle.md
PONG_AI_PADDLE -- requirements
Module: pong_ai_paddle

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- SQ_WIDTH, 16: square side length in pixels.
- PDL_HEIGHT, 96: paddle height in pixels.
- V_VIDEO, 480: active lines.
- HOME_Y, 191: paddle rest top coordinate.
- DEAD_ZONE, 8: tolerance in pixels, applied to both error terms.
- SAMPLE_PSC, 251_750: clk_0 cycles per sample tick (100 Hz).
- REACT_TICKS, 3: reaction delay in sample ticks.
REQ-002 Ports (name, direction, width, meaning):
- clk_0, in, 1: 25.175 MHz clock.
- rst, in, 1: reset; asynchronous, active-low.
- enable, in, 1: AI controls paddle 2 when high.
- sq_shown, in, 1: square visible.
- game_over, in, 1: game-over pulse.
- sq_xpos, in, 10: square left x.
- sq_ypos, in, 10: square top y.
- pdl_ypos, in, 10: controlled paddle top y.
- up_n, out, 1: active-low up request; drives up_p2.
- down_n, out, 1: active-low down request; drives down_p2.
- state, out, 3: FSM state.

Function
REQ-003 Sample counter shall count 0..SAMPLE_PSC-1 and wrap to 0. It shall assert the one-cycle internal tick when count==SAMPLE_PSC-1.
REQ-004 Error terms shall be 12-bit signed and computed from zero-extended inputs:
- err = (sq_ypos+SQ_WIDTH/2) - (pdl_ypos+PDL_HEIGHT/2).
- herr = (HOME_Y+PDL_HEIGHT/2) - (pdl_ypos+PDL_HEIGHT/2).
REQ-005 "approaching" shall be true when prev_valid==1 and sq_xpos > prev_x. On every tick, prev_x<=sq_xpos and prev_valid<=1.
REQ-006 State encoding shall be IDLE=0, WAIT=1, MOVE_UP=2, MOVE_DOWN=3, RECENTER=4.
REQ-007 Outputs shall be registered and decoded from the state:
- MOVE_UP, or RECENTER with herr<0: up_n=0.
- MOVE_DOWN, or RECENTER with herr>0: down_n=0.
- All other cases: both outputs 1.
- up_n and down_n shall never both be 0.
REQ-008 Abort: when enable==0, sq_shown==0 or game_over==1, the FSM shall go to IDLE on the next edge, release both outputs, and clear prev_valid. Abort shall take priority over all transitions.
REQ-009 IDLE, on tick:
- approaching and |err|>DEAD_ZONE: go to WAIT and load react_cnt=REACT_TICKS-1.
- not approaching and |herr|>DEAD_ZONE: go to RECENTER.
- otherwise: stay in IDLE.
REQ-010 WAIT, on tick:
- react_cnt!=0: decrement react_cnt.
- react_cnt==0 and |err|<=DEAD_ZONE or not approaching: go to IDLE.
- react_cnt==0 otherwise: go to MOVE_UP if err<0, else MOVE_DOWN.
REQ-011 MOVE_UP/MOVE_DOWN, on tick: go to IDLE when any of the following holds:
- |err|<=DEAD_ZONE;
- the sign of err opposes the current direction;
- the square is not approaching.
REQ-012 Boundary exit: these checks shall run every cycle, not only on ticks.
- MOVE_UP with pdl_ypos==0: go to IDLE.
- MOVE_DOWN with pdl_ypos+PDL_HEIGHT >= V_VIDEO-1: go to IDLE.
- Either exit shall release the output on the next edge.
REQ-013 RECENTER, on tick:
- approaching and |err|>DEAD_ZONE: go to WAIT with the react_cnt reload.
- else if |herr|<=DEAD_ZONE: go to IDLE.
REQ-014 RECENTER shall apply the same boundary exits as REQ-012, according to the active output.
REQ-015 Latency: an FSM state change shall be visible on up_n/down_n exactly one clk_0 cycle later.

Reset
REQ-016 While rst==0, the block shall hold: up_n=1, down_n=1, state=IDLE, sample counter=0, react_cnt=0, prev_x=0, prev_valid=0. These values shall take effect asynchronously, including when reset is asserted mid-move.
REQ-017 After rst deasserts, the first tick shall only load prev_x and shall not start a move.

Verification (SAMPLE_PSC=4, REACT_TICKS=2, DEAD_ZONE=8)
REQ-018 The bench shall cover the following directed scenarios:
- Approach above: pdl_ypos=191, sq_ypos=100, sq_xpos 300 then 302 on successive ticks -> WAIT; MOVE_UP after 2 further ticks; up_n=0 one cycle later; down_n=1 throughout.
- Dead zone: sq_ypos=227 (err=-4), approaching -> state stays IDLE; outputs stay 1.
- Top boundary: in MOVE_UP, force pdl_ypos=0 mid-interval -> IDLE on next edge; up_n=1 one cycle later.
- Receding recenter: sq_xpos 400 then 398, pdl_ypos=50 -> RECENTER, down_n=0; set pdl_ypos=188 -> IDLE at next tick.
- Abort: sq_shown=0 in WAIT -> IDLE next edge; the next tick after sq_shown=1 does not start WAIT.
- Reset: rst=0 in MOVE_DOWN -> up_n=down_n=1 and state=0 without a clock edge.
